// File: rtl/quad_decoder.sv
// Quadrature encoder front-end: 2-FF synchroniser, per-phase glitch filter, 1x/2x/4x decode,
// signed position, direction and error count. Optional step-period measurement: QUAD_DECODER_PERIOD_EN.
module quad_decoder #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic [1:0]  mode,
  input  logic        clear_pos,
  output logic        out_signal,
  output logic        out_dir,
  output logic [31:0] position,
  output logic [15:0] err_count,
  output logic [31:0] period,
  output logic        period_valid
);

  localparam logic [7:0] FLT_LEN = 8'(FILTER_LEN);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  init_cnt_q, init_cnt_d;
  logic        a_meta_q, a_s_q, b_meta_q, b_s_q;
  logic        a_f_q, a_f_d, b_f_q, b_f_d;
  logic [7:0]  a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [1:0]  prev_q, prev_d;
  logic        out_signal_q, out_signal_d;
  logic        out_dir_q, out_dir_d;
  logic [31:0] position_q, position_d;
  logic [15:0] err_q, err_d;

  logic [8:0]  a_filt_s, b_filt_s;
  logic [1:0]  cur_s, chg_s;
  logic        step_s, fwd_s, count_s;

  // Filter next state {level, counter}: count while the synchronised level differs from the
  // accepted level; accept once the counter has reached the configured length.
  function automatic logic [8:0] filt_next(input logic s, input logic f, input logic [7:0] cnt,
                                           input logic [7:0] len);
    logic [8:0] r;
    r = {f, 8'd0};
    if (s != f) begin
      if (cnt == len) begin
        r = {s, 8'd0};
      end else begin
        r = {f, cnt + 8'd1};
      end
    end else begin
      r = {f, 8'd0};
    end
    return r;
  endfunction

  // Position of a phase pair along the forward sequence 00->10->11->01.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    logic [1:0] r;
    case (ab)
      2'b00:   r = 2'd0;
      2'b10:   r = 2'd1;
      2'b11:   r = 2'd2;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  assign a_filt_s = filt_next(a_s_q, a_f_q, a_cnt_q, FLT_LEN);
  assign b_filt_s = filt_next(b_s_q, b_f_q, b_cnt_q, FLT_LEN);
  assign cur_s    = {a_f_q, b_f_q};
  assign chg_s    = cur_s ^ prev_q;

  // Next-state logic: INIT/RUN sequencing, filtering and step decode.
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    a_f_d        = a_f_q;
    b_f_d        = b_f_q;
    a_cnt_d      = a_cnt_q;
    b_cnt_d      = b_cnt_q;
    prev_d       = prev_q;
    out_signal_d = 1'b0;
    out_dir_d    = out_dir_q;
    err_d        = err_q;
    step_s       = 1'b0;
    fwd_s        = 1'b0;
    count_s      = 1'b0;
    case (state_q)
      ST_INIT: begin
        a_cnt_d = 8'd0;
        b_cnt_d = 8'd0;
        if (init_cnt_q == 2'd2) begin
          // Seed the filters and history from the settled inputs so nothing is decoded on entry.
          state_d = ST_RUN;
          a_f_d   = a_s_q;
          b_f_d   = b_s_q;
          prev_d  = {a_s_q, b_s_q};
        end else begin
          init_cnt_d = init_cnt_q + 2'd1;
        end
      end
      ST_RUN: begin
        a_f_d   = a_filt_s[8];
        a_cnt_d = a_filt_s[7:0];
        b_f_d   = b_filt_s[8];
        b_cnt_d = b_filt_s[7:0];
        prev_d  = cur_s;
        if (chg_s == 2'b11) begin
          if (err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
          end else begin
            err_d = err_q;
          end
        end else if (chg_s != 2'b00) begin
          case (mode)
            2'd0: begin
              count_s = chg_s[1] & cur_s[1];
              fwd_s   = ~cur_s[0];
            end
            2'd1: begin
              count_s = chg_s[1];
              fwd_s   = cur_s[1] ^ cur_s[0];
            end
            default: begin
              count_s = 1'b1;
              fwd_s   = ((gray_idx(cur_s) - gray_idx(prev_q)) == 2'd1);
            end
          endcase
          if (count_s) begin
            step_s       = 1'b1;
            out_dir_d    = fwd_s;
            out_signal_d = fwd_s;
          end else begin
            step_s = 1'b0;
          end
        end else begin
          step_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Position: clear wins over a same-cycle step; arithmetic wraps at 32 bits.
  always_comb begin
    position_d = position_q;
    if (clear_pos) begin
      position_d = 32'd0;
    end else if (step_s) begin
      if (fwd_s) begin
        position_d = position_q + 32'd1;
      end else begin
        position_d = position_q - 32'd1;
      end
    end else begin
      position_d = position_q;
    end
  end

  // Synchroniser, filter, FSM and decode registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      a_meta_q     <= 1'b0;
      a_s_q        <= 1'b0;
      b_meta_q     <= 1'b0;
      b_s_q        <= 1'b0;
      state_q      <= ST_INIT;
      init_cnt_q   <= 2'd0;
      a_f_q        <= 1'b0;
      b_f_q        <= 1'b0;
      a_cnt_q      <= 8'd0;
      b_cnt_q      <= 8'd0;
      prev_q       <= 2'b00;
      out_signal_q <= 1'b0;
      out_dir_q    <= 1'b1;
      position_q   <= 32'd0;
      err_q        <= 16'd0;
    end else begin
      a_meta_q     <= enc_a;
      a_s_q        <= a_meta_q;
      b_meta_q     <= enc_b;
      b_s_q        <= b_meta_q;
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      a_f_q        <= a_f_d;
      b_f_q        <= b_f_d;
      a_cnt_q      <= a_cnt_d;
      b_cnt_q      <= b_cnt_d;
      prev_q       <= prev_d;
      out_signal_q <= out_signal_d;
      out_dir_q    <= out_dir_d;
      position_q   <= position_d;
      err_q        <= err_d;
    end
  end

  assign out_signal = out_signal_q;
  assign out_dir    = out_dir_q;
  assign position   = position_q;
  assign err_count  = err_q;

`ifdef QUAD_DECODER_PERIOD_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [31:0] interval_q, interval_d;
  logic [31:0] period_q, period_d;
  logic        valid_q, valid_d;
  logic        seen_q, seen_d;

  // Interval between counted steps; a saturated counter reports a stalled belt.
  always_comb begin
    interval_d = interval_q;
    period_d   = period_q;
    valid_d    = valid_q;
    seen_d     = seen_q;
    if (step_s) begin
      if (interval_q == CNT_MAX) begin
        period_d = CNT_MAX;
      end else begin
        period_d = interval_q + 32'd1;
      end
      interval_d = 32'd0;
      seen_d     = 1'b1;
      valid_d    = valid_q | seen_q;
    end else if (interval_q == CNT_MAX) begin
      period_d = CNT_MAX;
    end else begin
      interval_d = interval_q + 32'd1;
    end
  end

  // Period measurement registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      interval_q <= 32'd0;
      period_q   <= 32'd0;
      valid_q    <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      interval_q <= interval_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      seen_q     <= seen_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
`else
  assign period       = 32'd0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (FILTER_LEN = 8); period checks follow QUAD_DECODER_PERIOD_EN.
module tb_quad_decoder;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        enc_a;
  logic        enc_b;
  logic [1:0]  mode;
  logic        clear_pos;
  logic        out_signal;
  logic        out_dir;
  logic [31:0] position;
  logic [15:0] err_count;
  logic [31:0] period;
  logic        period_valid;

  int n_vec = 0;
  int n_err = 0;
  int pulses = 0;

  quad_decoder #(.FILTER_LEN(8)) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .enc_a        (enc_a),
    .enc_b        (enc_b),
    .mode         (mode),
    .clear_pos    (clear_pos),
    .out_signal   (out_signal),
    .out_dir      (out_dir),
    .position     (position),
    .err_count    (err_count),
    .period       (period),
    .period_valid (period_valid)
  );

  always #5 sys_clk = ~sys_clk;

  // Pulse counter, sampled just after each rising edge.
  always @(posedge sys_clk) begin
    #1;
    if (out_signal === 1'b1) pulses <= pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic phase(input logic a, input logic b, input int n);
    enc_a = a;
    enc_b = b;
    cycles(n);
  endtask

  task automatic fwd_cycle();
    phase(1'b1, 1'b0, 20);
    phase(1'b1, 1'b1, 20);
    phase(1'b0, 1'b1, 20);
    phase(1'b0, 1'b0, 20);
  endtask

  initial begin
    int p0;
    int lat;
    logic [31:0] exp_period;
    logic [31:0] exp_valid;
`ifdef QUAD_DECODER_PERIOD_EN
    exp_period = 32'd100;
    exp_valid  = 32'd1;
`else
    exp_period = 32'd0;
    exp_valid  = 32'd0;
`endif
    enc_a = 1'b1; enc_b = 1'b1; mode = 2'd2; clear_pos = 1'b0; rst_n = 1'b0;
    cycles(3);
    chk("rst_out_signal", 32'(out_signal), 32'd0);
    chk("rst_out_dir", 32'(out_dir), 32'd1);
    chk("rst_position", position, 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_period", period, 32'd0);
    chk("rst_period_valid", 32'(period_valid), 32'd0);

    rst_n = 1'b1;
    cycles(20);
    chk("idle11_err", 32'(err_count), 32'd0);
    chk("idle11_pos", position, 32'd0);
    chk("idle11_pulses", 32'(pulses), 32'd0);

    // 4x forward cycle from 00 with latency measurement on the first A edge
    rst_n = 1'b0; enc_a = 1'b0; enc_b = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(20);
    p0 = pulses;
    lat = -1;
    enc_a = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge sys_clk);
      if (out_signal === 1'b1 && lat < 0) lat = k;
    end
    chk("fwd4x_latency", 32'(lat - 1), 32'd11);
    phase(1'b1, 1'b1, 20);
    phase(1'b0, 1'b1, 20);
    phase(1'b0, 1'b0, 20);
    chk("fwd4x_pos", position, 32'd4);
    chk("fwd4x_pulses", 32'(pulses - p0), 32'd4);
    chk("fwd4x_dir", 32'(out_dir), 32'd1);
    chk("fwd4x_err", 32'(err_count), 32'd0);

    clear_pos = 1'b1; cycles(1); clear_pos = 1'b0;
    chk("clear_pos", position, 32'd0);

    // 4x reverse cycle
    p0 = pulses;
    phase(1'b0, 1'b1, 20);
    phase(1'b1, 1'b1, 20);
    phase(1'b1, 1'b0, 20);
    phase(1'b0, 1'b0, 20);
    chk("rev4x_pos", position, 32'hFFFF_FFFC);
    chk("rev4x_pulses", 32'(pulses - p0), 32'd0);
    chk("rev4x_dir", 32'(out_dir), 32'd0);

    // 1x then 2x
    clear_pos = 1'b1; cycles(1); clear_pos = 1'b0;
    mode = 2'd0;
    p0 = pulses;
    fwd_cycle(); fwd_cycle(); fwd_cycle();
    chk("fwd1x_pos", position, 32'd3);
    chk("fwd1x_pulses", 32'(pulses - p0), 32'd3);
    chk("fwd1x_dir", 32'(out_dir), 32'd1);
    mode = 2'd1;
    fwd_cycle();
    chk("fwd2x_pos", position, 32'd5);
    chk("fwd2x_pulses", 32'(pulses - p0), 32'd5);

    // short glitch on A is filtered out
    p0 = pulses;
    phase(1'b1, 1'b0, 5);
    phase(1'b0, 1'b0, 20);
    chk("glitch_pos", position, 32'd5);
    chk("glitch_pulses", 32'(pulses - p0), 32'd0);

    // both phases flip together
    phase(1'b1, 1'b1, 20);
    chk("illegal_err", 32'(err_count), 32'd1);
    chk("illegal_pos", position, 32'd5);
    chk("illegal_dir", 32'(out_dir), 32'd1);

    // clear coinciding with a forward step (step lands on the 12th edge after the drive)
    mode = 2'd2;
    enc_a = 1'b0; enc_b = 1'b1;
    cycles(11);
    clear_pos = 1'b1;
    cycles(1);
    clear_pos = 1'b0;
    chk("clrstep_pos", position, 32'd0);
    chk("clrstep_pulse", 32'(out_signal), 32'd1);
    chk("clrstep_dir", 32'(out_dir), 32'd1);
    cycles(5);

    // two forward steps exactly 100 cycles apart
    phase(1'b0, 1'b0, 100);
    phase(1'b1, 1'b0, 20);
    chk("period_value", period, exp_period);
    chk("period_valid", 32'(period_valid), exp_valid);
    chk("period_pos", position, 32'd2);

    // reset in the middle of a filter run
    p0 = pulses;
    phase(1'b1, 1'b1, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_pos", position, 32'd0);
    chk("midrst_dir", 32'(out_dir), 32'd1);
    chk("midrst_err", 32'(err_count), 32'd0);
    chk("midrst_period", period, 32'd0);
    @(negedge sys_clk);
    cycles(2);
    rst_n = 1'b1;
    cycles(20);
    chk("postrst_err", 32'(err_count), 32'd0);
    chk("postrst_pos", position, 32'd0);
    chk("postrst_pulses", 32'(pulses - p0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Front-end for the conveyor rotary encoder: synchronises and glitch-filters the A/B quadrature phases, decodes direction and steps, and keeps a signed position count. Emits a one-cycle pulse per forward step on `out_signal`, wired straight to the `in_signal` input of the valve/camera trigger divider. Also reports direction, illegal-transition count and, optionally, the step period for belt-speed readback over AXI-lite.

## Interface
- `FILTER_LEN`, 8: cycles a synchronised phase must hold a new level before it is accepted (legal range 1..255).
- `sys_clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `enc_a`  in  1  encoder phase A, asynchronous.
- `enc_b`  in  1  encoder phase B, asynchronous.
- `mode`  in  2  resolution: 0 = 1x, 1 = 2x, 2/3 = 4x.
- `clear_pos`  in  1  synchronous clear of `position`.
- `out_signal`  out  1  one-cycle pulse per counted forward step.
- `out_dir`  out  1  1 = last counted step forward, 0 = reverse.
- `position`  out  32  signed step count.
- `err_count`  out  16  illegal-transition count, saturating.
- `period`  out  32  sys_clk cycles between the last two counted steps.
- `period_valid`  out  1  `period` holds a measured interval.

## Operation
- Synchroniser: each phase passes through 2 flip-flops, giving `a_s` and `b_s`.
- Filter:
  - Per-phase 8-bit counter runs while `x_s != x_f` and is cleared when they are equal.
  - When the counter reaches `FILTER_LEN`, `x_f <= x_s` and the counter clears.
- State machine, INIT then RUN:
  - INIT lasts 3 cycles after reset release.
  - On the INIT exit cycle, `a_f`/`b_f` are loaded directly from `a_s`/`b_s`; nothing is counted or flagged.
- Decode in RUN, comparing `{a_f,b_f}` against its registered previous value:
  - Forward (A leads) sequence: 00→10→11→01→00. The reverse sequence is the opposite order.
  - Both phases changing in the same cycle is illegal: `err_count` +1, saturating at 0xFFFF. No step is counted and `out_dir` holds.
- Counted steps by mode:
  - 1x: rising edge of `a_f` only. `b_f`=0 means forward, 1 means reverse.
  - 2x: any `a_f` edge. Forward when `a_f != b_f` after the edge.
  - 4x: every legal transition.
- Position and direction:
  - Forward step: `position` +1. Reverse step: `position` −1. Two's complement, wraps at 32 bits.
  - `out_dir` updates on every counted step.
- `out_signal`: asserted only for forward steps. Reverse steps never pulse it.
- `clear_pos`: sets `position` to 0 and discards a step in the same cycle. `out_signal` and `out_dir` still respond to that step.
- `mode` changes take effect the next cycle. `position` is not altered by a mode change.

## Timing
- Reset values: `out_signal` 0, `out_dir` 1, `position` 0, `err_count` 0, `period` 0, `period_valid` 0, filters 0, state INIT.
- Latency: a phase level stable from the first sampling edge T produces `out_signal` high in cycle T+FILTER_LEN+3, and `position` updated in the same cycle.
- Pulse spacing: consecutive `out_signal` pulses are at least 1 low cycle apart when the phases obey `FILTER_LEN`. A downstream 2-FF edge detector sees every pulse.
- Filter re-arm: a glitch shorter than `FILTER_LEN` cycles restarts the counter and produces no step.
- Reset mid-operation: all state returns to reset values immediately. INIT repeats after release, so no spurious step or error is produced.

## Configuration
- `QUAD_DECODER_PERIOD_EN` defined:
  - A 32-bit interval counter increments every cycle and saturates at 0xFFFFFFFF.
  - On each counted step (either direction), `period <= counter+1` and the counter clears.
  - `period_valid` rises on the second counted step after reset.
  - When the counter saturates, `period <= 0xFFFFFFFF` (stalled belt) and `period_valid` stays 1.
- Not defined: no counter logic is present; `period` and `period_valid` are tied to 0.

## Test plan
- Reset with `enc_a`=`enc_b`=1, release, hold 20 cycles -> `err_count` 0, `position` 0, no `out_signal`.
- 4x, `FILTER_LEN`=8, one forward cycle 00→10→11→01→00, 20 cycles per state -> `position` 4, 4 pulses, `out_dir` 1, first pulse 11 cycles after the first A edge.
- Same sequence reversed -> `position` −4 (0xFFFFFFFC), no pulses, `out_dir` 0.
- 1x, 3 forward quadrature cycles -> `position` 3, 3 pulses. Switch to 2x and run 1 more cycle -> `position` 5.
- 5-cycle glitch on A with `FILTER_LEN`=8 -> no step. A/B forced 00→11 with a simultaneous change -> `err_count` 1, `position` unchanged.
- Macro defined, forward steps 100 cycles apart -> `period` 100 and `period_valid` 1 after the second step. `clear_pos` asserted with a step in the same cycle -> `position` 0 and `out_signal` still pulses.
